// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: shared state encoding, geometry helper and width constants for the convolution scheduler
package conv_sched_pkg;
  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, DONE} state_e;
  localparam int RCW = 16;
  function automatic int out_size(input int n, input int f, input int p, input int s);
    return (n - f + 2 * p) / s + 1;
  endfunction
  function automatic int wid(input int v);
    return v > 1 ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/mult_pick_lsb.sv
// mult_pick_lsb: lowest-set-bit priority encoder for the free-unit snapshot
//   vec : candidate unit mask
//   idx : index of the lowest set bit (0 when vec is empty)
//   any : vec has at least one bit set
module mult_pick_lsb #(
  parameter int W  = 64,
  parameter int IW = 6
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) if (vec[i]) idx = IW'(i);
  end
  assign any = |vec;
endmodule

// File: rtl/conv_mult_sched.sv
// conv_mult_sched: enumerates convolution output points and issues them as jobs to free MAC units
//   clk, rstn              : clock, asynchronous active-low reset
//   en, start              : level enable (low aborts), layer start pulse
//   mult_Loc_in            : pool occupancy (1 = occupied)
//   mult_done_in           : per-unit completion pulses
//   job_valid/job_ready    : descriptor handshake
//   job_mult..job_k_cnt    : registered job descriptor fields
//   busy, partial, round_cnt, done : layer status
module conv_mult_sched
  import conv_sched_pkg::*;
#(
  parameter int N     = 32,
  parameter int F     = 3,
  parameter int K     = 3,
  parameter int NF    = 3,
  parameter int P     = 1,
  parameter int S     = 1,
  parameter int NMULT = 64,
  localparam int OUT  = out_size(N, F, P, S),
  localparam int JOBS = OUT * OUT * NF,
  localparam int IW   = wid(NMULT),
  localparam int FW   = wid(NF),
  localparam int OW   = wid(OUT),
  localparam int CW   = $clog2(N + 2 * P) + 1,
  localparam int KW   = wid(K + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 start,
  input  logic [NMULT-1:0]     mult_Loc_in,
  input  logic [NMULT-1:0]     mult_done_in,
  output logic                 job_valid,
  input  logic                 job_ready,
  output logic [IW-1:0]        job_mult,
  output logic [FW-1:0]        job_filt,
  output logic [OW-1:0]        job_oy,
  output logic [OW-1:0]        job_ox,
  output logic signed [CW-1:0] job_iy,
  output logic signed [CW-1:0] job_ix,
  output logic [KW-1:0]        job_k_cnt,
  output logic                 job_last,
  output logic                 busy,
  output logic                 partial,
  output logic [RCW-1:0]       round_cnt,
  output logic                 done
);
  localparam int JW = $clog2(JOBS + 1);
  state_e cs_q, cs_d;
  logic [NMULT-1:0] snap_q, snap_d, outst_q, outst_d, mask, snap_clr, pick_in;
  logic [IW-1:0] mult_q, mult_d, pick_idx;
  logic [FW-1:0] filt_q, filt_d;
  logic [OW-1:0] oy_q, oy_d, ox_q, ox_d;
  logic signed [CW-1:0] iy_q, iy_d, ix_q, ix_d;
  logic [KW-1:0] kc_q, kc_d;
  logic [JW-1:0] issued_q, issued_d;
  logic [RCW-1:0] round_q, round_d;
  logic valid_q, valid_d, last_q, last_d, busy_q, busy_d, partial_q, partial_d, done_q, done_d;
  logic pick_any, acc, ox_w, oy_w, is_last;

  function automatic int popcount(input logic [NMULT-1:0] v);
    popcount = 0;
    for (int i = 0; i < NMULT; i++) popcount += int'(v[i]);
  endfunction

  assign mask     = NMULT'(1) << mult_q;
  assign acc      = cs_q == ISSUE && valid_q && job_ready;
  assign snap_clr = snap_q & ~mask;
  assign pick_in  = cs_q == SCAN ? ~mult_Loc_in : snap_clr;
  assign is_last  = issued_q == JW'(JOBS - 1);
  assign ox_w     = ox_q == OW'(OUT - 1);
  assign oy_w     = oy_q == OW'(OUT - 1);

  mult_pick_lsb #(.W(NMULT), .IW(IW)) u_pick (.vec(pick_in), .idx(pick_idx), .any(pick_any));

  always_comb begin
    cs_d      = cs_q;
    snap_d    = snap_q;
    outst_d   = outst_q & ~mult_done_in;
    mult_d    = mult_q;
    filt_d    = filt_q;
    oy_d      = oy_q;
    ox_d      = ox_q;
    issued_d  = issued_q;
    round_d   = round_q;
    partial_d = partial_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    case (cs_q)
      IDLE: if (start) begin
        cs_d      = SCAN;
        outst_d   = '0;
        filt_d    = '0;
        oy_d      = '0;
        ox_d      = '0;
        issued_d  = '0;
        round_d   = '0;
        partial_d = 1'b0;
      end
      SCAN: if (pick_any) begin
        cs_d      = ISSUE;
        snap_d    = ~mult_Loc_in;
        partial_d = popcount(~mult_Loc_in) < JOBS - int'(issued_q);
        round_d   = round_q + RCW'(1);
        valid_d   = 1'b1;
        mult_d    = pick_idx;
      end
      ISSUE: if (acc) begin
        snap_d   = snap_clr;
        outst_d  = outst_d | mask;
        ox_d     = ox_w ? '0 : ox_q + OW'(1);
        oy_d     = ox_w ? (oy_w ? '0 : oy_q + OW'(1)) : oy_q;
        filt_d   = ox_w && oy_w ? (filt_q == FW'(NF - 1) ? '0 : filt_q + FW'(1)) : filt_q;
        issued_d = issued_q + JW'(1);
        valid_d  = pick_any && !is_last;
        mult_d   = pick_idx;
        cs_d     = pick_any && !is_last ? ISSUE : WAIT;
      end
      WAIT: if (outst_d == '0) cs_d = issued_q == JW'(JOBS) ? DONE : SCAN;
      DONE: begin
        cs_d   = IDLE;
        done_d = 1'b1;
      end
      default: cs_d = IDLE;
    endcase
    if (!en) begin
      cs_d    = IDLE;
      valid_d = 1'b0;
      snap_d  = '0;
      outst_d = '0;
      done_d  = 1'b0;
    end
    // descriptor fields are reloaded only alongside a valid descriptor so they hold otherwise
    iy_d   = valid_d ? CW'(int'(oy_d) * S - P) : iy_q;
    ix_d   = valid_d ? CW'(int'(ox_d) * S - P) : ix_q;
    kc_d   = valid_d ? KW'(K) : kc_q;
    last_d = valid_d && issued_d == JW'(JOBS - 1);
    busy_d = cs_d == SCAN || cs_d == ISSUE || cs_d == WAIT;
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cs_q      <= IDLE;
      snap_q    <= '0;
      outst_q   <= '0;
      mult_q    <= '0;
      filt_q    <= '0;
      oy_q      <= '0;
      ox_q      <= '0;
      iy_q      <= '0;
      ix_q      <= '0;
      kc_q      <= '0;
      issued_q  <= '0;
      round_q   <= '0;
      partial_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cs_q      <= cs_d;
      snap_q    <= snap_d;
      outst_q   <= outst_d;
      mult_q    <= mult_d;
      filt_q    <= filt_d;
      oy_q      <= oy_d;
      ox_q      <= ox_d;
      iy_q      <= iy_d;
      ix_q      <= ix_d;
      kc_q      <= kc_d;
      issued_q  <= issued_d;
      round_q   <= round_d;
      partial_q <= partial_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end

  assign job_valid = valid_q;
  assign job_mult  = mult_q;
  assign job_filt  = filt_q;
  assign job_oy    = oy_q;
  assign job_ox    = ox_q;
  assign job_iy    = iy_q;
  assign job_ix    = ix_q;
  assign job_k_cnt = kc_q;
  assign job_last  = last_q;
  assign busy      = busy_q;
  assign partial   = partial_q;
  assign round_cnt = round_q;
  assign done      = done_q;
endmodule

// File: tb/tb_conv_mult_sched.sv
// tb_conv_mult_sched: randomized self-checking bench against a job-enumeration reference model
module tb_conv_mult_sched;
  localparam int NF = 2, NM = 8, OUT = 4, JOBS = OUT * OUT * NF, P = 1, S = 1;
  logic clk = 1'b0, rstn = 1'b0, en = 1'b0, start = 1'b0, ready = 1'b0;
  logic [NM-1:0] loc = '0, mdone = '0;
  logic jv, jl, busy, partial, done;
  logic [2:0] jm;
  logic [0:0] jf;
  logic [1:0] joy, jox, jk;
  logic signed [3:0] jiy, jix;
  logic [15:0] rc;
  logic en_b = 1'b0, start_b = 1'b0;
  logic [NM-1:0] mdone_b = '0;
  logic jv_b, jl_b, busy_b, partial_b, done_b;
  logic [2:0] jm_b;
  logic [0:0] jf_b, joy_b, jox_b;
  logic [1:0] jk_b;
  logic signed [3:0] jiy_b, jix_b;
  logic [15:0] rc_b;
  int tests = 0, fails = 0;
  int idx, dcnt, rmode, abort_at;
  int cd [NM];
  logic tog = 1'b0;

  always #5 clk = ~clk;

  conv_mult_sched #(.N(4), .F(3), .K(3), .NF(NF), .P(P), .S(S), .NMULT(NM)) dut (
    .clk(clk), .rstn(rstn), .en(en), .start(start), .mult_Loc_in(loc), .mult_done_in(mdone),
    .job_valid(jv), .job_ready(ready), .job_mult(jm), .job_filt(jf), .job_oy(joy), .job_ox(jox),
    .job_iy(jiy), .job_ix(jix), .job_k_cnt(jk), .job_last(jl), .busy(busy), .partial(partial),
    .round_cnt(rc), .done(done));

  conv_mult_sched #(.N(5), .F(3), .K(3), .NF(2), .P(0), .S(2), .NMULT(NM)) dut_b (
    .clk(clk), .rstn(rstn), .en(en_b), .start(start_b), .mult_Loc_in(8'h00), .mult_done_in(mdone_b),
    .job_valid(jv_b), .job_ready(1'b1), .job_mult(jm_b), .job_filt(jf_b), .job_oy(joy_b), .job_ox(jox_b),
    .job_iy(jiy_b), .job_ix(jix_b), .job_k_cnt(jk_b), .job_last(jl_b), .busy(busy_b), .partial(partial_b),
    .round_cnt(rc_b), .done(done_b));

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d (job %0d, t=%0t)", tag, got, exp, idx, $time);
    end
  endtask

  function automatic int nth_free(input logic [NM-1:0] m, input int n);
    int c = 0;
    for (int i = 0; i < NM; i++) if (!m[i]) begin
      if (c == n) return i;
      c++;
    end
    return -1;
  endfunction

  task automatic step();
    int fr, r;
    @(negedge clk);
    mdone = '0;
    for (int i = 0; i < NM; i++) if (cd[i] > 0) begin
      cd[i]--;
      if (cd[i] == 0) mdone[i] = 1'b1;
    end
    if (en && abort_at >= 0 && idx == abort_at) en = 1'b0;
    ready = !en ? 1'b0 : rmode == 0 ? 1'b1 : rmode == 1 ? tog : 1'($urandom_range(0, 1));
    tog = ~tog;
    if (done) dcnt++;
    fr = NM - $countones(loc);
    if (jv) begin
      if (fr == 0 || idx >= JOBS) check("spurious_valid", 1, 0);
      else begin
        r = idx / fr;
        check("job_mult", int'(jm), nth_free(loc, idx % fr));
        check("job_filt", int'(jf), idx / (OUT * OUT));
        check("job_oy", int'(joy), (idx / OUT) % OUT);
        check("job_ox", int'(jox), idx % OUT);
        check("job_iy", int'(jiy), ((idx / OUT) % OUT) * S - P);
        check("job_ix", int'(jix), (idx % OUT) * S - P);
        check("job_k", int'(jk), 3);
        check("job_last", int'(jl), int'(idx == JOBS - 1));
        check("partial", int'(partial), int'(fr < JOBS - r * fr));
        check("round_cnt", int'(rc), r + 1);
        if (ready) begin
          cd[jm] = 2;
          idx++;
        end
      end
    end
  endtask

  task automatic run_layer(input logic [NM-1:0] m, input int mode, input int ab, input int hold);
    int cyc = 0, fr;
    idx = 0; dcnt = 0; rmode = mode; abort_at = ab;
    for (int i = 0; i < NM; i++) cd[i] = 0;
    loc = hold > 0 ? 8'hFF : m;
    @(negedge clk);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < hold; c++) begin
      step();
      check("scan_hold_valid", int'(jv), 0);
      check("scan_hold_busy", int'(busy), 1);
    end
    loc = m;
    fr = NM - $countones(m);
    while (dcnt == 0 && cyc < 2000 && en) begin
      step();
      cyc++;
    end
    if (!en) begin
      step();
      check("abort_valid", int'(jv), 0);
      check("abort_busy", int'(busy), 0);
      repeat (3) step();
      check("abort_no_done", dcnt, 0);
      check("abort_jobs", idx, ab);
      en = 1'b1;
      return;
    end
    if (cyc >= 2000) check("timeout", 0, 1);
    repeat (3) step();
    check("done_pulses", dcnt, 1);
    check("jobs_issued", idx, JOBS);
    check("rounds", int'(rc), (JOBS + fr - 1) / fr);
    check("busy_end", int'(busy), 0);
  endtask

  initial begin
    logic [NM-1:0] rm;
    int kb, cyc;
    abort_at = -1; rmode = 0; idx = 0;
    #1;
    check("rst_valid", int'(jv), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_round", int'(rc), 0);
    check("rst_iy", int'(jiy), 0);
    check("rst_ix", int'(jix), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1; en = 1'b1; en_b = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_valid", int'(jv), 0);
    check("idle_iy", int'(jiy), 0);
    run_layer(8'h00, 0, -1, 0);
    run_layer(8'hAA, 0, -1, 0);
    run_layer(8'h00, 0, -1, 10);
    run_layer(8'h00, 1, -1, 0);
    run_layer(8'h00, 0, 5, 0);
    run_layer(8'h00, 0, -1, 0);
    repeat (4) begin
      rm = 8'($urandom);
      if (rm == 8'hFF) rm[$urandom_range(0, 7)] = 1'b0;
      run_layer(rm, 2, -1, 0);
    end
    mdone = '0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    kb = 0; cyc = 0;
    while (!done_b && cyc < 200) begin
      @(negedge clk);
      cyc++;
      mdone_b = kb == 8 ? 8'hFF : 8'h00;
      if (jv_b) begin
        check("b_mult", int'(jm_b), kb);
        check("b_filt", int'(jf_b), kb / 4);
        check("b_iy", int'(jiy_b), ((kb / 2) % 2) * 2);
        check("b_ix", int'(jix_b), (kb % 2) * 2);
        check("b_last", int'(jl_b), int'(kb == 7));
        check("b_partial", int'(partial_b), 0);
        kb++;
      end
    end
    if (cyc >= 200) check("b_timeout", 0, 1);
    check("b_jobs", kb, 8);
    check("b_rounds", int'(rc_b), 1);
    mdone_b = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
